// File: rtl/csr_file_trap_pkg.sv
// csr_file_trap_pkg
//   Shared definitions for the machine-mode CSR file:
//   - 12-bit CSR addresses (machine CSRs, counters, user read-only aliases)
//   - mstatus bit indices (MIE, MPIE) and mie/mip bit indices (MSI, MTI, MEI)
//   - mstatus next-value source selector
//   - helpers: writability decode and WARL legalisation of write data
package csr_file_trap_pkg;

  localparam logic [11:0] CSR_NONE      = 12'h000;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIX_MSI      = 3;
  localparam int MIX_MTI      = 7;
  localparam int MIX_MEI      = 11;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

  typedef enum logic [1:0] {
    MST_HOLD  = 2'd0,
    MST_WRITE = 2'd1,
    MST_TRAP  = 2'd2,
    MST_MRET  = 2'd3
  } mst_src_e;

  // CSRs that software may write (read-only aliases, mip and mhartid excluded)
  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Legal stored value for a write; counter high halves are masked by the top
  function automatic logic [31:0] csr_warl(input logic [11:0] addr, input logic [31:0] data);
    case (addr)
      CSR_MSTATUS: return data & MSTATUS_WMASK;
      CSR_MIE:     return data & MIE_WMASK;
      // reserved vector modes 2/3 collapse to direct mode
      CSR_MTVEC:   return data[1] ? {data[31:2], 2'b00} : data;
      CSR_MEPC:    return {data[31:2], 2'b00};
      default:     return data;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_trap_counter.sv
// csr_counter
//   Free-running CNT_W-bit counter with independent low/high half writes.
//   A write to either half replaces that half and suppresses the increment
//   for that cycle; otherwise it increments when inc_i is set and wraps.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   inc_i           increment enable
//   lo_we_i/lo_data_i  write bits [31:0]
//   hi_we_i/hi_data_i  write bits [CNT_W-1:32] from hi_data_i[CNT_W-33:0]
//   cnt_o           current count
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             lo_we_i,
  input  logic [31:0]      lo_data_i,
  input  logic             hi_we_i,
  input  logic [31:0]      hi_data_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int HW = CNT_W - 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_hi_s;

  assign unused_hi_s = ^hi_data_i;
  assign cnt_o       = cnt_q;

  // Next count: half writes take precedence over the increment
  always_comb begin
    cnt_d = cnt_q;
    if (lo_we_i || hi_we_i) begin
      if (lo_we_i) begin
        cnt_d[31:0] = lo_data_i;
      end else begin
        cnt_d[31:0] = cnt_q[31:0];
      end
      if (hi_we_i) begin
        cnt_d[CNT_W-1:32] = hi_data_i[HW-1:0];
      end else begin
        cnt_d[CNT_W-1:32] = cnt_q[CNT_W-1:32];
      end
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csr_file_trap.sv
// csr_file_trap
//   Machine-mode CSR file for the rv32i core with trap entry / mret
//   sequencing, interrupt-pending tracking and cycle/instret counters.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   we_i/raddr_i/waddr_i/data_i   ex-stage access port (higher priority)
//   data_o                        ex read data (combinational, write bypass)
//   clint_*                       clint access port, clint_data_o likewise
//   trap_i/trap_cause_i/trap_pc_i trap entry strobe with cause and pc
//   mret_i                        trap return strobe
//   instret_i                     instruction retired this cycle
//   irq_sw_i/irq_timer_i/irq_ext_i level interrupt sources
//   clint_csr_mtvec/mepc/mstatus  architectural CSR values
//   global_int_en_o               mstatus.MIE
//   int_req_o                     registered qualified interrupt request
module csr_file_trap
  import csr_file_trap_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] HART_ID   = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [31:0]     raddr_i,
  input  logic [31:0]     waddr_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  input  logic            clint_we_i,
  input  logic [31:0]     clint_raddr_i,
  input  logic [31:0]     clint_waddr_i,
  input  logic [XLEN-1:0] clint_data_i,
  output logic [XLEN-1:0] clint_data_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  output logic [XLEN-1:0] clint_csr_mtvec,
  output logic [XLEN-1:0] clint_csr_mepc,
  output logic [XLEN-1:0] clint_csr_mstatus,
  output logic            global_int_en_o,
  output logic            int_req_o
);

  localparam int HW = CNT_W - 32;

  logic [11:0] ex_ra_s, ex_wa_s, cl_ra_s, cl_wa_s;
  logic [11:0] port_wa_s [2];
  logic [31:0] port_wd_s [2];

  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] mip_q, mip_d;
  logic        int_req_q, int_req_d;

  mst_src_e    mst_src_s;
  logic [31:0] mst_wdata_s;

  logic             cyc_lo_we_s, cyc_hi_we_s, ins_lo_we_s, ins_hi_we_s;
  logic [31:0]      cyc_lo_wd_s, cyc_hi_wd_s, ins_lo_wd_s, ins_hi_wd_s;
  logic [CNT_W-1:0] mcycle_s, minstret_s;
  logic             unused_s;

  assign ex_ra_s = raddr_i[11:0];
  assign ex_wa_s = waddr_i[11:0];
  assign cl_ra_s = clint_raddr_i[11:0];
  assign cl_wa_s = clint_waddr_i[11:0];
  assign unused_s = ^{raddr_i[31:12], waddr_i[31:12], clint_raddr_i[31:12],
                      clint_waddr_i[31:12], trap_pc_i[1:0]};

  // Write ports in ascending priority; an idle port decodes to no CSR
  always_comb begin
    port_wa_s[0] = clint_we_i ? cl_wa_s : CSR_NONE;
    port_wd_s[0] = clint_data_i;
    port_wa_s[1] = we_i ? ex_wa_s : CSR_NONE;
    port_wd_s[1] = data_i;
  end

  // Software writes applied clint then ex (ex overrides), then trap/mret
  always_comb begin
    mie_d       = mie_q;
    mtvec_d     = mtvec_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mst_src_s   = MST_HOLD;
    mst_wdata_s = mstatus_q;
    cyc_lo_we_s = 1'b0;
    cyc_hi_we_s = 1'b0;
    ins_lo_we_s = 1'b0;
    ins_hi_we_s = 1'b0;
    cyc_lo_wd_s = 32'h0;
    cyc_hi_wd_s = 32'h0;
    ins_lo_wd_s = 32'h0;
    ins_hi_wd_s = 32'h0;
    for (int i = 0; i < 2; i++) begin
      case (port_wa_s[i])
        CSR_MSTATUS: begin
          mst_src_s   = MST_WRITE;
          mst_wdata_s = csr_warl(CSR_MSTATUS, port_wd_s[i]);
        end
        CSR_MIE:       mie_d      = csr_warl(CSR_MIE, port_wd_s[i]);
        CSR_MTVEC:     mtvec_d    = csr_warl(CSR_MTVEC, port_wd_s[i]);
        CSR_MSCRATCH:  mscratch_d = port_wd_s[i];
        CSR_MEPC:      mepc_d     = csr_warl(CSR_MEPC, port_wd_s[i]);
        CSR_MCAUSE:    mcause_d   = port_wd_s[i];
        CSR_MCYCLE:    begin cyc_lo_we_s = 1'b1; cyc_lo_wd_s = port_wd_s[i]; end
        CSR_MCYCLEH:   begin cyc_hi_we_s = 1'b1; cyc_hi_wd_s = port_wd_s[i]; end
        CSR_MINSTRET:  begin ins_lo_we_s = 1'b1; ins_lo_wd_s = port_wd_s[i]; end
        CSR_MINSTRETH: begin ins_hi_we_s = 1'b1; ins_hi_wd_s = port_wd_s[i]; end
        default: ;
      endcase
    end
    // trap drops same-cycle software writes to mepc/mcause/mstatus
    if (trap_i) begin
      mepc_d    = {trap_pc_i[31:2], 2'b00};
      mcause_d  = trap_cause_i;
      mst_src_s = MST_TRAP;
    end else if (mret_i) begin
      mst_src_s = MST_MRET;
    end else begin
      mst_src_s = mst_src_s;
    end
  end

  // mstatus next value from the selected source
  always_comb begin
    mstatus_d = mstatus_q;
    case (mst_src_s)
      MST_WRITE: mstatus_d = mst_wdata_s;
      MST_TRAP: begin
        mstatus_d               = 32'h0;
        mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      end
      MST_MRET: begin
        mstatus_d               = 32'h0;
        mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
        mstatus_d[MSTATUS_MPIE] = 1'b1;
      end
      default: mstatus_d = mstatus_q;
    endcase
  end

  // Pending bits sampled from the sources; request qualified by current state
  always_comb begin
    mip_d          = 32'h0;
    mip_d[MIX_MSI] = irq_sw_i;
    mip_d[MIX_MTI] = irq_timer_i;
    mip_d[MIX_MEI] = irq_ext_i;
    int_req_d      = mstatus_q[MSTATUS_MIE] & (|(mip_q & mie_q));
  end

  // Architectural CSR registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= 32'h0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mip_q      <= 32'h0;
      int_req_q  <= 1'b0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mip_q      <= mip_d;
      int_req_q  <= int_req_d;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (1'b1),
    .lo_we_i   (cyc_lo_we_s),
    .lo_data_i (cyc_lo_wd_s),
    .hi_we_i   (cyc_hi_we_s),
    .hi_data_i (cyc_hi_wd_s),
    .cnt_o     (mcycle_s)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (instret_i),
    .lo_we_i   (ins_lo_we_s),
    .lo_data_i (ins_lo_wd_s),
    .hi_we_i   (ins_hi_we_s),
    .hi_data_i (ins_hi_wd_s),
    .cnt_o     (minstret_s)
  );

  function automatic logic [31:0] csr_read(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS:                 return mstatus_q;
      CSR_MIE:                     return mie_q;
      CSR_MTVEC:                   return mtvec_q;
      CSR_MSCRATCH:                return mscratch_q;
      CSR_MEPC:                    return mepc_q;
      CSR_MCAUSE:                  return mcause_q;
      CSR_MIP:                     return mip_q;
      CSR_MCYCLE, CSR_CYCLE:       return mcycle_s[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     return 32'(mcycle_s[CNT_W-1:32]);
      CSR_MINSTRET, CSR_INSTRET:   return minstret_s[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: return 32'(minstret_s[CNT_W-1:32]);
      CSR_MHARTID:                 return HART_ID;
      default:                     return 32'h0;
    endcase
  endfunction

  // Value a write would store, as seen through the read bypass
  function automatic logic [31:0] wr_value(input logic [11:0] addr, input logic [31:0] data);
    if (addr == CSR_MCYCLEH || addr == CSR_MINSTRETH) begin
      return 32'(data[HW-1:0]);
    end else begin
      return csr_warl(addr, data);
    end
  endfunction

  // ex read port, bypassing only its own write
  always_comb begin
    if (we_i && (ex_wa_s == ex_ra_s) && csr_writable(ex_wa_s)) begin
      data_o = wr_value(ex_wa_s, data_i);
    end else begin
      data_o = csr_read(ex_ra_s);
    end
  end

  // clint read port; ex writes become visible here one cycle later
  always_comb begin
    if (clint_we_i && (cl_wa_s == cl_ra_s) && csr_writable(cl_wa_s)) begin
      clint_data_o = wr_value(cl_wa_s, clint_data_i);
    end else begin
      clint_data_o = csr_read(cl_ra_s);
    end
  end

  assign clint_csr_mtvec   = mtvec_q;
  assign clint_csr_mepc    = mepc_q;
  assign clint_csr_mstatus = mstatus_q;
  assign global_int_en_o   = mstatus_q[MSTATUS_MIE];
  assign int_req_o         = int_req_q;

endmodule

// File: tb/tb_csr_file_trap.sv
// Directed bench for csr_file_trap: stimulus pushes expected values into a
// scoreboard queue tagged with the cycle they are due; a monitor pops and
// compares them on the falling edge.
module tb_csr_file_trap;

  localparam int SEL_DATA   = 0;
  localparam int SEL_CDATA  = 1;
  localparam int SEL_MTVEC  = 2;
  localparam int SEL_MEPC   = 3;
  localparam int SEL_MST    = 4;
  localparam int SEL_GIE    = 5;
  localparam int SEL_INTREQ = 6;

  logic        clk, rst;
  logic        we_i, clint_we_i, trap_i, mret_i, instret_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic [31:0] raddr_i, waddr_i, data_i, data_o;
  logic [31:0] clint_raddr_i, clint_waddr_i, clint_data_i, clint_data_o;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic [31:0] clint_csr_mtvec, clint_csr_mepc, clint_csr_mstatus;
  logic        global_int_en_o, int_req_o;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } chk_t;

  chk_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  csr_file_trap #(
    .XLEN(32), .CNT_W(40), .HART_ID(32'h0000_0005), .MTVEC_RST(32'h0000_0080)
  ) dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .raddr_i(raddr_i), .waddr_i(waddr_i), .data_i(data_i), .data_o(data_o),
    .clint_we_i(clint_we_i), .clint_raddr_i(clint_raddr_i), .clint_waddr_i(clint_waddr_i),
    .clint_data_i(clint_data_i), .clint_data_o(clint_data_o),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .mret_i(mret_i),
    .instret_i(instret_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
    .clint_csr_mtvec(clint_csr_mtvec), .clint_csr_mepc(clint_csr_mepc),
    .clint_csr_mstatus(clint_csr_mstatus), .global_int_en_o(global_int_en_o),
    .int_req_o(int_req_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_DATA:   return data_o;
      SEL_CDATA:  return clint_data_o;
      SEL_MTVEC:  return clint_csr_mtvec;
      SEL_MEPC:   return clint_csr_mepc;
      SEL_MST:    return clint_csr_mstatus;
      SEL_GIE:    return {31'h0, global_int_en_o};
      default:    return {31'h0, int_req_o};
    endcase
  endfunction

  // Monitor: compare every entry that has come due
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        act = pick(sb_q[i].sel);
        checks++;
        if (act !== sb_q[i].exp) begin
          errors++;
          $display("FAIL %s: actual=%h expected=%h (cycle %0d)", sb_q[i].name, act, sb_q[i].exp, cyc);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input string name, input int sel, input logic [31:0] exp, input int dly);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    c.due  = cyc + dly;
    sb_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    we_i = 1'b0; clint_we_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
  endtask

  task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
  endtask

  task automatic cl_wr(input logic [31:0] a, input logic [31:0] d);
    clint_we_i = 1'b1; clint_waddr_i = a; clint_data_i = d;
  endtask

  initial begin
    rst = 1'b0;
    we_i = 1'b0; clint_we_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
    irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    raddr_i = 32'h0; waddr_i = 32'h0; data_i = 32'h0;
    clint_raddr_i = 32'h0; clint_waddr_i = 32'h0; clint_data_i = 32'h0;
    trap_cause_i = 32'h0; trap_pc_i = 32'h0;
    tick();
    tick();

    // reset state
    raddr_i = 32'hF14; clint_raddr_i = 32'h305;
    expect_at("rst_mtvec", SEL_MTVEC, 32'h80, 0);
    expect_at("rst_mstatus", SEL_MST, 32'h0, 0);
    expect_at("rst_intreq", SEL_INTREQ, 32'h0, 0);
    expect_at("rst_hartid", SEL_DATA, 32'h5, 0);
    expect_at("rst_clint_mtvec", SEL_CDATA, 32'h80, 0);
    tick();
    rst = 1'b1;
    tick();

    // trap entry, with a dropped ex write to mepc
    ex_wr(32'h300, 32'h8);
    tick();
    raddr_i = 32'h300;
    expect_at("pre_trap_mstatus", SEL_MST, 32'h8, 0);
    expect_at("pre_trap_gie", SEL_GIE, 32'h1, 0);
    expect_at("pre_trap_read", SEL_DATA, 32'h8, 0);
    trap_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h106;
    ex_wr(32'h341, 32'h55);
    expect_at("trap_mepc", SEL_MEPC, 32'h104, 1);
    expect_at("trap_mstatus", SEL_MST, 32'h80, 1);
    expect_at("trap_gie", SEL_GIE, 32'h0, 1);
    tick();
    raddr_i = 32'h342; clint_raddr_i = 32'h341;
    expect_at("trap_mcause", SEL_DATA, 32'h8000_000B, 0);
    expect_at("trap_mepc_clint", SEL_CDATA, 32'h104, 0);
    tick();

    // mret with a dropped ex write to mstatus
    mret_i = 1'b1;
    ex_wr(32'h300, 32'h0);
    expect_at("mret_mstatus", SEL_MST, 32'h88, 1);
    expect_at("mret_gie", SEL_GIE, 32'h1, 1);
    tick();

    // trap and mret together: trap wins; clint write to mscratch proceeds
    trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'h3; trap_pc_i = 32'h200;
    cl_wr(32'h340, 32'hABCD);
    expect_at("trapmret_mstatus", SEL_MST, 32'h80, 1);
    expect_at("trapmret_mepc", SEL_MEPC, 32'h200, 1);
    tick();
    raddr_i = 32'h342; clint_raddr_i = 32'h340;
    expect_at("trapmret_mcause", SEL_DATA, 32'h3, 0);
    expect_at("trap_mscratch", SEL_CDATA, 32'hABCD, 0);
    tick();

    // interrupt path: source at N, mip at N+1, int_req at N+2
    ex_wr(32'h300, 32'h8);
    cl_wr(32'h304, 32'h80);
    tick();
    irq_timer_i = 1'b1;
    expect_at("irq_req_n0", SEL_INTREQ, 32'h0, 0);
    expect_at("irq_req_n1", SEL_INTREQ, 32'h0, 1);
    expect_at("irq_req_n2", SEL_INTREQ, 32'h1, 2);
    tick();
    raddr_i = 32'h344;
    expect_at("irq_mip", SEL_DATA, 32'h80, 0);
    tick();
    tick();
    ex_wr(32'h304, 32'h0);
    expect_at("mie_clr_req_1", SEL_INTREQ, 32'h1, 1);
    expect_at("mie_clr_req_2", SEL_INTREQ, 32'h0, 2);
    tick();
    irq_timer_i = 1'b0;
    tick();

    // counters: set mcycle to all ones then observe wrap
    ex_wr(32'hB80, 32'hFF);
    cl_wr(32'hB00, 32'hFFFF_FFFF);
    tick();
    raddr_i = 32'hC00; clint_raddr_i = 32'hC80;
    expect_at("cyc_lo_max", SEL_DATA, 32'hFFFF_FFFF, 0);
    expect_at("cyc_hi_max", SEL_CDATA, 32'hFF, 0);
    tick();
    expect_at("cyc_lo_wrap", SEL_DATA, 32'h0, 0);
    expect_at("cyc_hi_wrap", SEL_CDATA, 32'h0, 0);
    tick();
    raddr_i = 32'hB80;
    ex_wr(32'hB80, 32'h1234_5678);
    expect_at("cyc_hi_bypass", SEL_DATA, 32'h78, 0);
    tick();

    // minstret write wins over the increment
    ex_wr(32'hB02, 32'h1234);
    instret_i = 1'b1;
    tick();
    raddr_i = 32'hB02; clint_raddr_i = 32'hB82;
    expect_at("instret_written", SEL_DATA, 32'h1234, 0);
    expect_at("instreth_zero", SEL_CDATA, 32'h0, 0);
    instret_i = 1'b1;
    tick();
    raddr_i = 32'hC02;
    expect_at("instret_inc", SEL_DATA, 32'h1235, 0);
    tick();

    // bypass and WARL
    raddr_i = 32'h305; clint_raddr_i = 32'h305;
    ex_wr(32'h305, 32'h1003);
    expect_at("mtvec_ex_bypass", SEL_DATA, 32'h1000, 0);
    expect_at("mtvec_no_xbypass", SEL_CDATA, 32'h80, 0);
    expect_at("mtvec_stored", SEL_MTVEC, 32'h1000, 1);
    tick();
    cl_wr(32'h305, 32'h2001);
    expect_at("mtvec_clint_bypass", SEL_CDATA, 32'h2001, 0);
    expect_at("mtvec_ex_old", SEL_DATA, 32'h1000, 0);
    expect_at("mtvec_mode1", SEL_MTVEC, 32'h2001, 1);
    tick();
    raddr_i = 32'h304; clint_raddr_i = 32'h300;
    ex_wr(32'h304, 32'hFFFF_FFFF);
    cl_wr(32'h300, 32'hFFFF_FFFF);
    expect_at("mie_warl", SEL_DATA, 32'h888, 0);
    expect_at("mstatus_warl", SEL_CDATA, 32'h88, 0);
    expect_at("mstatus_warl_reg", SEL_MST, 32'h88, 1);
    tick();
    raddr_i = 32'h344;
    ex_wr(32'h344, 32'h888);
    expect_at("mip_readonly", SEL_DATA, 32'h0, 0);
    tick();
    raddr_i = 32'h7C0; clint_raddr_i = 32'h7C0;
    ex_wr(32'h7C0, 32'hDEAD);
    expect_at("unmapped_bypass", SEL_DATA, 32'h0, 0);
    tick();
    expect_at("unmapped_read", SEL_CDATA, 32'h0, 0);
    tick();

    for (int k = 0; k < 8 && sb_q.size() > 0; k++) tick();
    if (sb_q.size() > 0) begin
      $display("FAIL drain: actual=%0d pending expected=0", sb_q.size());
      errors = errors + sb_q.size();
      checks = checks + sb_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_file_trap.md
Name: csr_file_trap

Overview:
Parametrised machine-mode CSR file for the rv32i core, with atomic trap entry/exit sequencing. Provides:
- Two read/write ports: ex stage (priority) and clint.
- Hardware interrupt-pending tracking (mip).
- Configurable-width cycle/instret counters.
Sits beside ex and clint. Outputs mtvec/mepc/mstatus and a qualified interrupt request to clint.

Parameters:
XLEN, 32, CSR data width (32 only supported for rv32i; kept for package use)
CNT_W, 64, width of mcycle/minstret (33..64); the high half reads zero-extended
HART_ID, 0, value returned by mhartid
MTVEC_RST, 0, reset value of mtvec

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
we_i  in  1  ex write enable
raddr_i  in  32  ex read address, bits[11:0] decoded
waddr_i  in  32  ex write address, bits[11:0] decoded
data_i  in  XLEN  ex write data
data_o  out  XLEN  ex read data (combinational)
clint_we_i  in  1  clint write enable
clint_raddr_i  in  32  clint read address
clint_waddr_i  in  32  clint write address
clint_data_i  in  XLEN  clint write data
clint_data_o  out  XLEN  clint read data (combinational)
trap_i  in  1  trap entry strobe (one cycle)
trap_cause_i  in  XLEN  mcause value for trap
trap_pc_i  in  XLEN  mepc value for trap
mret_i  in  1  trap return strobe
instret_i  in  1  one instruction retired this cycle
irq_sw_i / irq_timer_i / irq_ext_i  in  1 each  level interrupt sources
clint_csr_mtvec  out  XLEN  mtvec
clint_csr_mepc  out  XLEN  mepc
clint_csr_mstatus  out  XLEN  mstatus
global_int_en_o  out  1  mstatus.MIE
int_req_o  out  1  registered: MIE & |(mip & mie)

Behaviour:
- Reset (rst low, asynchronous):
  - mtvec=MTVEC_RST; all other CSRs and counters 0.
  - int_req_o=0.
  - data_o and clint_data_o follow the reset state combinationally.
- Address map:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82 (read-only aliases).
  - mhartid 0xF14.
  - Unmapped addresses read 0; writes to them are ignored.
- Per-cycle update priority: trap_i > mret_i > ex write > clint write. Only one of these may modify a given CSR in a cycle.
- Trap entry (trap_i=1), effective next edge:
  - mepc<=trap_pc_i & ~3; mcause<=trap_cause_i.
  - MPIE(bit7)<=MIE(bit3); MIE<=0.
  - A same-cycle ex/clint write to mepc, mcause or mstatus is dropped. Writes to other CSRs proceed.
- mret (mret_i=1, trap_i=0):
  - MIE<=MPIE; MPIE<=1.
  - A same-cycle ex write to mstatus is dropped.
  - trap_i and mret_i together: trap wins; mret is ignored.
- WARL write rules:
  - mepc bits[1:0] forced 0.
  - mtvec MODE (bits[1:0]) values 2/3 are stored as 0.
  - mstatus: only bits 3 and 7 are writable; others read 0.
  - mie: only bits 3, 7, 11 are writable.
  - mip and mhartid are read-only.
- mip[3]/[7]/[11] are registered each cycle from irq_sw_i/irq_timer_i/irq_ext_i (1-cycle latency).
- int_req_o is registered from the current mstatus/mie/mip, so a source asserted in cycle N gives int_req_o=1 in cycle N+2.
- Counters:
  - mcycle increments every cycle; minstret increments when instret_i=1.
  - Both wrap from 2^CNT_W-1 to 0.
  - A write to the low or high half replaces that half and suppresses the increment for that cycle.
  - The high half holds CNT_W-32 bits, zero-extended on read.
- Read bypass, per port: if write enable is set and waddr[11:0]==raddr[11:0] on a writable CSR, the read returns the post-WARL write data.
  - ex write in the same cycle is not bypassed to the clint port; it becomes visible there the next cycle.

Decomposition:
- Shared package (rv32i_defines.v):
  - CSR address defines (including the new MIP, MHARTID, MINSTRET*, INSTRET* entries).
  - mstatus bit indices MIE=3, MPIE=7.
  - mie/mip bit indices MSI=3, MTI=7, MEI=11.
- Sub-module csr_counter (parametrised CNT_W):
  - Increment enable, low/high write ports, wrap.
  - Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset: hold rst=0 with MTVEC_RST=0x80 -> clint_csr_mtvec=0x80, mstatus=0, int_req_o=0. Read 0xF14 -> HART_ID.
- Trap: mstatus=0x8, trap_i, cause=0x8000000B, pc=0x106 -> next cycle mepc=0x104, mcause=0x8000000B, mstatus=0x80. A same-cycle ex write of 0x55 to mepc is dropped.
- mret: after the trap case, mret_i -> mstatus=0x88. trap_i+mret_i together -> trap result only.
- Interrupt: mstatus=0x8, mie=0x80, irq_timer_i rises at N -> mip reads 0x80 at N+1, int_req_o=1 at N+2. Clear mie -> int_req_o=0 two cycles later.
- Counters (CNT_W=40): write mcycleh=0xFF and mcycle=0xFFFFFFFF -> after one cycle, cycle reads 0 and cycleh reads 0 (wrap). Write of minstret with instret_i=1 -> exact written value, no increment.
- Bypass/WARL: ex writes mtvec=0x1003 while reading 0x305 -> data_o=0x1000 same cycle. Unmapped 0x7C0 write/read -> 0.
